fetch_unit: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register.
- Consumes the current PC, issues word reads to instruction memory with a ready handshake, and fills the IF/ID pipeline register.
- Produces the PC register's next-PC value and update enable.
- Handles ID-stage stalls with a one-entry holding buffer, and handles flush/redirect from branch resolution.

---
 rtl/fetch_unit.sv | 191 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives instruction memory, fills IF/ID, and feeds the PC register.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] pc_cur,
    output logic [WORD_SIZE-1:0] pc_next,
    output logic                 pc_update,
    output logic                 mem_read,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0] mem_data,
    input  logic                 mem_ready,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 if_id_valid,
    output logic [WORD_SIZE-1:0] if_id_instr,
    output logic [WORD_SIZE-1:0] if_id_pc,
    output logic [WORD_SIZE-1:0] if_id_pc_plus1
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0]          fetch_count,
    output logic [31:0]          bubble_count
`endif
);

    localparam logic [WORD_SIZE-1:0] ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] req_addr_q, req_addr_d;
    logic [WORD_SIZE-1:0] hold_instr_q, hold_instr_d;
    logic [WORD_SIZE-1:0] hold_pc_q, hold_pc_d;
    logic                 if_id_valid_q, if_id_valid_d;
    logic [WORD_SIZE-1:0] if_id_instr_q, if_id_instr_d;
    logic [WORD_SIZE-1:0] if_id_pc_q, if_id_pc_d;
    logic [WORD_SIZE-1:0] if_id_pc_plus1_q, if_id_pc_plus1_d;
    logic [WORD_SIZE-1:0] req_addr_plus1;
    logic [WORD_SIZE-1:0] hold_pc_plus1;

    assign req_addr_plus1 = req_addr_q + ONE;
    assign hold_pc_plus1  = hold_pc_q + ONE;

    always_comb begin
        state_d          = state_q;
        req_addr_d       = req_addr_q;
        hold_instr_d     = hold_instr_q;
        hold_pc_d        = hold_pc_q;
        if_id_valid_d    = if_id_valid_q;
        if_id_instr_d    = if_id_instr_q;
        if_id_pc_d       = if_id_pc_q;
        if_id_pc_plus1_d = if_id_pc_plus1_q;
        pc_next          = pc_cur;
        pc_update        = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (flush) begin
                    pc_update  = 1'b1;
                    pc_next    = redirect_pc;
                    req_addr_d = redirect_pc;
                end else begin
                    req_addr_d = pc_cur;
                end
            end
            REQ: begin
                if (flush) begin
                    pc_update     = 1'b1;
                    pc_next       = redirect_pc;
                    if_id_valid_d = 1'b0;
                    if (mem_ready) begin
                        req_addr_d = redirect_pc;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (mem_ready && !stall) begin
                    if_id_valid_d    = 1'b1;
                    if_id_instr_d    = mem_data;
                    if_id_pc_d       = req_addr_q;
                    if_id_pc_plus1_d = req_addr_plus1;
                    pc_next          = req_addr_plus1;
                    pc_update        = 1'b1;
                    req_addr_d       = req_addr_plus1;
                end else if (mem_ready) begin
                    hold_instr_d = mem_data;
                    hold_pc_d    = req_addr_q;
                    state_d      = HOLD;
                end else if (!stall) begin
                    if_id_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (flush) begin
                    if_id_valid_d = 1'b0;
                    pc_update     = 1'b1;
                    pc_next       = redirect_pc;
                    req_addr_d    = redirect_pc;
                    state_d       = REQ;
                end else if (!stall) begin
                    if_id_valid_d    = 1'b1;
                    if_id_instr_d    = hold_instr_q;
                    if_id_pc_d       = hold_pc_q;
                    if_id_pc_plus1_d = hold_pc_plus1;
                    pc_next          = hold_pc_plus1;
                    pc_update        = 1'b1;
                    req_addr_d       = hold_pc_plus1;
                    state_d          = REQ;
                end
            end
            DRAIN: begin
                if (flush) begin
                    pc_update = 1'b1;
                    pc_next   = redirect_pc;
                end
                // A flush landing on the drain's final cycle has not reached pc_cur yet.
                if (mem_ready) begin
                    req_addr_d = flush ? redirect_pc : pc_cur;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!reset_n) begin
            pc_update = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            req_addr_q       <= '0;
            hold_instr_q     <= '0;
            hold_pc_q        <= '0;
            if_id_valid_q    <= 1'b0;
            if_id_instr_q    <= '0;
            if_id_pc_q       <= RESET_PC;
            if_id_pc_plus1_q <= RESET_PC + ONE;
        end else begin
            state_q          <= state_d;
            req_addr_q       <= req_addr_d;
            hold_instr_q     <= hold_instr_d;
            hold_pc_q        <= hold_pc_d;
            if_id_valid_q    <= if_id_valid_d;
            if_id_instr_q    <= if_id_instr_d;
            if_id_pc_q       <= if_id_pc_d;
            if_id_pc_plus1_q <= if_id_pc_plus1_d;
        end
    end

    assign mem_read       = (state_q == REQ) || (state_q == DRAIN);
    assign mem_addr       = req_addr_q;
    assign if_id_valid    = if_id_valid_q;
    assign if_id_instr    = if_id_instr_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_pc_plus1 = if_id_pc_plus1_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] bubble_count_q, bubble_count_d;
    logic        fetch_inc;
    logic        bubble_inc;

    always_comb begin
        fetch_inc = ((state_q == REQ) && !flush && mem_ready && !stall) ||
                    ((state_q == HOLD) && !flush && !stall);
        bubble_inc = !if_id_valid_d &&
                     ((state_q == REQ) || (state_q == DRAIN) || ((state_q == HOLD) && flush));
        fetch_count_d  = fetch_count_q + (fetch_inc ? 32'd1 : 32'd0);
        bubble_count_d = bubble_count_q + (bubble_inc ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_count_q  <= '0;
            bubble_count_q <= '0;
        end else begin
            fetch_count_q  <= fetch_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign fetch_count  = fetch_count_q;
    assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: a small PC register and memory model surround the DUT.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [15:0] pc_cur;
    logic [15:0] pc_next;
    logic        pc_update;
    logic        mem_read;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        stall;
    logic        flush;
    logic [15:0] redirect_pc;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pc_plus1;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pc_cur         (pc_cur),
        .pc_next        (pc_next),
        .pc_update      (pc_update),
        .mem_read       (mem_read),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_ready      (mem_ready),
        .stall          (stall),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus1 (if_id_pc_plus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The memory answers every address with 0xA000 + address.
    assign mem_data = 16'hA000 + mem_addr;

    always @(posedge clk) begin
        if (!reset_n) pc_cur <= 16'h0000;
        else if (pc_update) pc_cur <= pc_next;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; stall = 1'b0; mem_ready = 1'b0; redirect_pc = 16'h0000;
        tick(); tick();
        #1;
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got=%h exp=%h", if_id_valid, 1'b0); end
        total++; if (if_id_instr !== 16'h0000) begin bad++; $display("[TB] FAIL rst_instr got=%h exp=%h", if_id_instr, 16'h0000); end
        total++; if (if_id_pc !== 16'h0000) begin bad++; $display("[TB] FAIL rst_pc got=%h exp=%h", if_id_pc, 16'h0000); end
        total++; if (if_id_pc_plus1 !== 16'h0001) begin bad++; $display("[TB] FAIL rst_pc_plus1 got=%h exp=%h", if_id_pc_plus1, 16'h0001); end
        total++; if (mem_read !== 1'b0) begin bad++; $display("[TB] FAIL rst_mem_read got=%h exp=%h", mem_read, 1'b0); end
        total++; if (mem_addr !== 16'h0000) begin bad++; $display("[TB] FAIL rst_mem_addr got=%h exp=%h", mem_addr, 16'h0000); end
        total++; if (pc_update !== 1'b0) begin bad++; $display("[TB] FAIL rst_pc_update got=%h exp=%h", pc_update, 1'b0); end
        reset_n = 1'b1;
        #1;
        total++; if (mem_read !== 1'b0) begin bad++; $display("[TB] FAIL idle_mem_read got=%h exp=%h", mem_read, 1'b0); end
        total++; if (pc_update !== 1'b0) begin bad++; $display("[TB] FAIL idle_pc_update got=%h exp=%h", pc_update, 1'b0); end
        tick();
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'b1; stall = 1'b0;
            #1;
            total++; if (mem_read !== 1'b1) begin bad++; $display("[TB] FAIL zw_mem_read[%0d] got=%h exp=%h", i, mem_read, 1'b1); end
            total++; if (mem_addr !== 16'(i)) begin bad++; $display("[TB] FAIL zw_mem_addr[%0d] got=%h exp=%h", i, mem_addr, 16'(i)); end
            total++; if (pc_update !== 1'b1) begin bad++; $display("[TB] FAIL zw_pc_update[%0d] got=%h exp=%h", i, pc_update, 1'b1); end
            total++; if (pc_next !== 16'(i + 1)) begin bad++; $display("[TB] FAIL zw_pc_next[%0d] got=%h exp=%h", i, pc_next, 16'(i + 1)); end
            if (i == 0) begin
                total++; if (if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL zw_first_valid got=%h exp=%h", if_id_valid, 1'b0); end
            end
            tick();
            total++; if (if_id_valid !== 1'b1) begin bad++; $display("[TB] FAIL zw_valid[%0d] got=%h exp=%h", i, if_id_valid, 1'b1); end
            total++; if (if_id_instr !== 16'(16'hA000 + i)) begin bad++; $display("[TB] FAIL zw_instr[%0d] got=%h exp=%h", i, if_id_instr, 16'(16'hA000 + i)); end
            total++; if (if_id_pc !== 16'(i)) begin bad++; $display("[TB] FAIL zw_pc[%0d] got=%h exp=%h", i, if_id_pc, 16'(i)); end
            total++; if (if_id_pc_plus1 !== 16'(i + 1)) begin bad++; $display("[TB] FAIL zw_pc_plus1[%0d] got=%h exp=%h", i, if_id_pc_plus1, 16'(i + 1)); end
        end
    endtask

    task automatic test_mem_wait();
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'b0; stall = 1'b0;
            #1;
            total++; if (mem_read !== 1'b1) begin bad++; $display("[TB] FAIL wait_mem_read[%0d] got=%h exp=%h", k, mem_read, 1'b1); end
            total++; if (mem_addr !== 16'h0005) begin bad++; $display("[TB] FAIL wait_mem_addr[%0d] got=%h exp=%h", k, mem_addr, 16'h0005); end
            total++; if (pc_update !== 1'b0) begin bad++; $display("[TB] FAIL wait_pc_update[%0d] got=%h exp=%h", k, pc_update, 1'b0); end
            tick();
            total++; if (if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL wait_bubble[%0d] got=%h exp=%h", k, if_id_valid, 1'b0); end
        end
        mem_ready = 1'b1;
        #1;
        total++; if (pc_next !== 16'h0006) begin bad++; $display("[TB] FAIL wait_pc_next got=%h exp=%h", pc_next, 16'h0006); end
        total++; if (pc_update !== 1'b1) begin bad++; $display("[TB] FAIL wait_pc_update_done got=%h exp=%h", pc_update, 1'b1); end
        tick();
        total++; if (if_id_valid !== 1'b1) begin bad++; $display("[TB] FAIL wait_valid got=%h exp=%h", if_id_valid, 1'b1); end
        total++; if (if_id_instr !== 16'hA005) begin bad++; $display("[TB] FAIL wait_instr got=%h exp=%h", if_id_instr, 16'hA005); end
        total++; if (if_id_pc_plus1 !== 16'h0006) begin bad++; $display("[TB] FAIL wait_pc_plus1 got=%h exp=%h", if_id_pc_plus1, 16'h0006); end
    endtask

    task automatic test_stall_hold();
        mem_ready = 1'b1; stall = 1'b0;
        tick(); tick();
        stall = 1'b1;
        #1;
        total++; if (mem_addr !== 16'h0008) begin bad++; $display("[TB] FAIL stall_mem_addr got=%h exp=%h", mem_addr, 16'h0008); end
        total++; if (pc_update !== 1'b0) begin bad++; $display("[TB] FAIL stall_pc_update got=%h exp=%h", pc_update, 1'b0); end
        tick();
        total++; if (if_id_pc !== 16'h0007) begin bad++; $display("[TB] FAIL stall_frozen_pc got=%h exp=%h", if_id_pc, 16'h0007); end
        mem_ready = 1'b0; stall = 1'b1;
        #1;
        total++; if (mem_read !== 1'b0) begin bad++; $display("[TB] FAIL hold_mem_read got=%h exp=%h", mem_read, 1'b0); end
        total++; if (pc_update !== 1'b0) begin bad++; $display("[TB] FAIL hold_pc_update got=%h exp=%h", pc_update, 1'b0); end
        total++; if (pc_cur !== 16'h0008) begin bad++; $display("[TB] FAIL hold_pc_cur got=%h exp=%h", pc_cur, 16'h0008); end
        tick();
        total++; if (if_id_instr !== 16'hA007) begin bad++; $display("[TB] FAIL hold_frozen_instr got=%h exp=%h", if_id_instr, 16'hA007); end
        total++; if (if_id_valid !== 1'b1) begin bad++; $display("[TB] FAIL hold_frozen_valid got=%h exp=%h", if_id_valid, 1'b1); end
        stall = 1'b0;
        #1;
        total++; if (pc_update !== 1'b1) begin bad++; $display("[TB] FAIL release_pc_update got=%h exp=%h", pc_update, 1'b1); end
        total++; if (pc_next !== 16'h0009) begin bad++; $display("[TB] FAIL release_pc_next got=%h exp=%h", pc_next, 16'h0009); end
        tick();
        total++; if (if_id_pc !== 16'h0008) begin bad++; $display("[TB] FAIL release_pc got=%h exp=%h", if_id_pc, 16'h0008); end
        total++; if (if_id_instr !== 16'hA008) begin bad++; $display("[TB] FAIL release_instr got=%h exp=%h", if_id_instr, 16'hA008); end
        total++; if (if_id_pc_plus1 !== 16'h0009) begin bad++; $display("[TB] FAIL release_pc_plus1 got=%h exp=%h", if_id_pc_plus1, 16'h0009); end
    endtask

    task automatic test_flush_drain();
        flush = 1'b1; mem_ready = 1'b1; redirect_pc = 16'h0003;
        #1;
        total++; if (pc_next !== 16'h0003) begin bad++; $display("[TB] FAIL fr_pc_next got=%h exp=%h", pc_next, 16'h0003); end
        total++; if (pc_update !== 1'b1) begin bad++; $display("[TB] FAIL fr_pc_update got=%h exp=%h", pc_update, 1'b1); end
        tick();
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL fr_valid got=%h exp=%h", if_id_valid, 1'b0); end
        total++; if (mem_addr !== 16'h0003) begin bad++; $display("[TB] FAIL fr_mem_addr got=%h exp=%h", mem_addr, 16'h0003); end
        flush = 1'b0; mem_ready = 1'b0;
        tick();
        flush = 1'b1; redirect_pc = 16'h0040;
        #1;
        total++; if (pc_next !== 16'h0040) begin bad++; $display("[TB] FAIL fd_pc_next got=%h exp=%h", pc_next, 16'h0040); end
        total++; if (pc_update !== 1'b1) begin bad++; $display("[TB] FAIL fd_pc_update got=%h exp=%h", pc_update, 1'b1); end
        tick();
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL fd_valid got=%h exp=%h", if_id_valid, 1'b0); end
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (mem_read !== 1'b1) begin bad++; $display("[TB] FAIL drain_mem_read[%0d] got=%h exp=%h", k, mem_read, 1'b1); end
            total++; if (mem_addr !== 16'h0003) begin bad++; $display("[TB] FAIL drain_mem_addr[%0d] got=%h exp=%h", k, mem_addr, 16'h0003); end
            total++; if (pc_update !== 1'b0) begin bad++; $display("[TB] FAIL drain_pc_update[%0d] got=%h exp=%h", k, pc_update, 1'b0); end
            tick();
        end
        mem_ready = 1'b1;
        tick();
        total++; if (mem_addr !== 16'h0040) begin bad++; $display("[TB] FAIL post_drain_addr got=%h exp=%h", mem_addr, 16'h0040); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_drain_valid got=%h exp=%h", if_id_valid, 1'b0); end
        #1;
        total++; if (pc_next !== 16'h0041) begin bad++; $display("[TB] FAIL post_drain_pc_next got=%h exp=%h", pc_next, 16'h0041); end
        tick();
        total++; if (if_id_instr !== 16'hA040) begin bad++; $display("[TB] FAIL post_drain_instr got=%h exp=%h", if_id_instr, 16'hA040); end
        total++; if (if_id_pc !== 16'h0040) begin bad++; $display("[TB] FAIL post_drain_pc got=%h exp=%h", if_id_pc, 16'h0040); end
    endtask

    task automatic test_wrap();
        flush = 1'b1; mem_ready = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        flush = 1'b0;
        #1;
        total++; if (mem_addr !== 16'hFFFF) begin bad++; $display("[TB] FAIL wrap_mem_addr got=%h exp=%h", mem_addr, 16'hFFFF); end
        total++; if (pc_next !== 16'h0000) begin bad++; $display("[TB] FAIL wrap_pc_next got=%h exp=%h", pc_next, 16'h0000); end
        tick();
        total++; if (if_id_pc !== 16'hFFFF) begin bad++; $display("[TB] FAIL wrap_pc got=%h exp=%h", if_id_pc, 16'hFFFF); end
        total++; if (if_id_pc_plus1 !== 16'h0000) begin bad++; $display("[TB] FAIL wrap_pc_plus1 got=%h exp=%h", if_id_pc_plus1, 16'h0000); end
        total++; if (if_id_instr !== 16'h9FFF) begin bad++; $display("[TB] FAIL wrap_instr got=%h exp=%h", if_id_instr, 16'h9FFF); end
    endtask

    task automatic test_flush_stall_hold();
        mem_ready = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b1; mem_ready = 1'b0; redirect_pc = 16'h0123;
        #1;
        total++; if (pc_next !== 16'h0123) begin bad++; $display("[TB] FAIL fsh_pc_next got=%h exp=%h", pc_next, 16'h0123); end
        total++; if (pc_update !== 1'b1) begin bad++; $display("[TB] FAIL fsh_pc_update got=%h exp=%h", pc_update, 1'b1); end
        total++; if (mem_read !== 1'b0) begin bad++; $display("[TB] FAIL fsh_mem_read got=%h exp=%h", mem_read, 1'b0); end
        tick();
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL fsh_valid got=%h exp=%h", if_id_valid, 1'b0); end
        total++; if (mem_addr !== 16'h0123) begin bad++; $display("[TB] FAIL fsh_mem_addr got=%h exp=%h", mem_addr, 16'h0123); end
        flush = 1'b0; stall = 1'b0; mem_ready = 1'b1;
        #1;
        total++; if (pc_next !== 16'h0124) begin bad++; $display("[TB] FAIL fsh_next_fetch got=%h exp=%h", pc_next, 16'h0124); end
        tick();
        total++; if (if_id_instr !== 16'hA123) begin bad++; $display("[TB] FAIL fsh_instr got=%h exp=%h", if_id_instr, 16'hA123); end
        total++; if (if_id_pc !== 16'h0123) begin bad++; $display("[TB] FAIL fsh_pc got=%h exp=%h", if_id_pc, 16'h0123); end
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        total++; if (mem_read !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_mem_read got=%h exp=%h", mem_read, 1'b0); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_valid got=%h exp=%h", if_id_valid, 1'b0); end
        total++; if (if_id_pc_plus1 !== 16'h0001) begin bad++; $display("[TB] FAIL mid_rst_pc_plus1 got=%h exp=%h", if_id_pc_plus1, 16'h0001); end
        total++; if (mem_addr !== 16'h0000) begin bad++; $display("[TB] FAIL mid_rst_mem_addr got=%h exp=%h", mem_addr, 16'h0000); end
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_mem_wait();
        test_stall_hold();
        test_flush_drain();
        test_wrap();
        test_flush_stall_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
